// File: rtl/execute_muldiv_if.sv
// Decode/hazard-facing bundle of the iterative M-extension unit.
// The master side issues requests and hazard controls; the slave side is the unit.
interface execute_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic [2:0]      function_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;
  logic [4:0]      rd_address_in;
  logic            stall;
  logic            invalidate;
  logic            busy;
  logic            valid_out;
  logic [XLEN-1:0] result_out;
  logic [4:0]      rd_address_out;

  modport master (
    output valid_in, function_in, rs1_data_in, rs2_data_in, rd_address_in,
    output stall, invalidate,
    input  busy, valid_out, result_out, rd_address_out
  );

  modport slave (
    input  valid_in, function_in, rs1_data_in, rs2_data_in, rd_address_in,
    input  stall, invalidate,
    output busy, valid_out, result_out, rd_address_out
  );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative RISC-V MUL/MULH*/DIV*/REM* unit: shift-add multiply and restoring
// divide on operand magnitudes, STEP bits per cycle, sign fix-up on the way out.
//
// state  | meaning
// S_IDLE | waiting for a request, busy low
// S_MUL  | shift-add iterations, cnt_q counts down to terminal count 0
// S_DIV  | restoring-division iterations, same counter
// S_DONE | result ready; registered toward memory on the first non-stalled edge
module execute_muldiv #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  execute_muldiv_if.slave bus
);
  localparam int N     = XLEN / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q;
  logic [2:0]        func_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic              rneg_q;
  logic              special_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              s1_signed, s2_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_val;

  always_comb begin
    s1_signed = (bus.function_in == 3'd1) || (bus.function_in == 3'd2) ||
                (bus.function_in == 3'd4) || (bus.function_in == 3'd6);
    s2_signed = (bus.function_in == 3'd1) || (bus.function_in == 3'd4) ||
                (bus.function_in == 3'd6);
    a_neg = s1_signed && bus.rs1_data_in[XLEN-1];
    b_neg = s2_signed && bus.rs2_data_in[XLEN-1];
    a_mag = a_neg ? (~bus.rs1_data_in + 1'b1) : bus.rs1_data_in;
    b_mag = b_neg ? (~bus.rs2_data_in + 1'b1) : bus.rs2_data_in;
    div_zero = bus.function_in[2] && (bus.rs2_data_in == '0);
    div_ovf  = ((bus.function_in == 3'd4) || (bus.function_in == 3'd6)) &&
               (bus.rs1_data_in == INT_MIN) && (bus.rs2_data_in == '1);
    // function_in[1] separates REM/REMU from DIV/DIVU
    if (div_zero)
      special_val = bus.function_in[1] ? bus.rs1_data_in : '1;
    else
      special_val = bus.function_in[1] ? '0 : bus.rs1_data_in;
  end

  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_d;

  always_comb begin
    mul_hi  = acc_q[2*XLEN-1:XLEN];
    mul_lo  = acc_q[XLEN-1:0];
    mul_sum = '0;
    for (int i = 0; i < STEP; i++) begin
      mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      {mul_hi, mul_lo} = {mul_sum, mul_lo[XLEN-1:1]};
    end
    mul_d = {mul_hi, mul_lo};
  end

  // acc_q holds {partial remainder, dividend shifting into quotient}
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [XLEN:0]     div_trial, div_diff;
  logic [2*XLEN-1:0] div_d;

  always_comb begin
    div_rem   = acc_q[2*XLEN-1:XLEN];
    div_quo   = acc_q[XLEN-1:0];
    div_trial = '0;
    div_diff  = '0;
    for (int i = 0; i < STEP; i++) begin
      div_trial = {div_rem, div_quo[XLEN-1]};
      div_diff  = div_trial - {1'b0, opb_q};
      div_rem   = div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
      div_quo   = {div_quo[XLEN-2:0], ~div_diff[XLEN]};
    end
    div_d = {div_rem, div_quo};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   result_d;

  always_comb begin
    prod = neg_q  ? (~acc_q + 1'b1) : acc_q;
    quot = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem  = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    if (special_q) begin
      result_d = acc_q[XLEN-1:0];
    end else begin
      case (func_q)
        3'd0:                result_d = prod[XLEN-1:0];
        3'd1, 3'd2, 3'd3:    result_d = prod[2*XLEN-1:XLEN];
        3'd4, 3'd5:          result_d = quot;
        default:             result_d = rem;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      rd_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else if (bus.invalidate) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      if (!bus.stall) valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.valid_in) begin
            func_q    <= bus.function_in;
            rd_q      <= bus.rd_address_in;
            opb_q     <= b_mag;
            cnt_q     <= CNT_W'(N - 1);
            neg_q     <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            if (div_zero || div_ovf) begin
              acc_q     <= {{XLEN{1'b0}}, special_val};
              special_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              acc_q     <= {{XLEN{1'b0}}, a_mag};
              special_q <= 1'b0;
              state_q   <= bus.function_in[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_DONE;
        end
        S_DIV: begin
          acc_q <= div_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          if (!bus.stall) begin
            valid_q  <= 1'b1;
            result_q <= result_d;
            rd_out_q <= rd_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.valid_out      = valid_q;
  assign bus.result_out     = result_q;
  assign bus.rd_address_out = rd_out_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: STEP=1 and STEP=4 instances share one stimulus
// stream and are checked against an arithmetic model of the M extension.
module tb_execute_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        valid_in, stall, invalidate;
  logic [2:0]  func;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;

  execute_muldiv_if #(.XLEN(XLEN)) bus1 ();
  execute_muldiv_if #(.XLEN(XLEN)) bus4 ();

  assign bus1.valid_in = valid_in;   assign bus4.valid_in = valid_in;
  assign bus1.function_in = func;    assign bus4.function_in = func;
  assign bus1.rs1_data_in = rs1;     assign bus4.rs1_data_in = rs1;
  assign bus1.rs2_data_in = rs2;     assign bus4.rs2_data_in = rs2;
  assign bus1.rd_address_in = rd;    assign bus4.rd_address_in = rd;
  assign bus1.stall = stall;         assign bus4.stall = stall;
  assign bus1.invalidate = invalidate; assign bus4.invalidate = invalidate;

  execute_muldiv #(.XLEN(XLEN), .STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  execute_muldiv #(.XLEN(XLEN), .STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ua, ub;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) ||
           (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  // Issues one request and observes both units until their results appear.
  // Edge k is the k-th rising edge after the accept edge; stall is high on edges sf..st.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input int sf, input int st,
                        output int lat1, output int lat4, output int busy1, output int pulse1,
                        output logic [31:0] r1, output logic [31:0] r4, output logic [4:0] rd1);
    lat1 = -1; lat4 = -1; busy1 = 0; pulse1 = 0; r1 = '0; r4 = '0; rd1 = '0;
    @(negedge clk);
    func = f; rs1 = a; rs2 = b; rd = d; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    busy1 += bus1.busy ? 1 : 0;
    for (int k = 1; k <= 90; k++) begin
      stall = (k >= sf) && (k <= st);
      @(posedge clk); #1;
      busy1 += bus1.busy ? 1 : 0;
      if (bus1.valid_out) begin
        pulse1++;
        if (lat1 < 0) begin
          lat1 = k; r1 = bus1.result_out; rd1 = bus1.rd_address_out;
        end
      end
      if (bus4.valid_out && lat4 < 0) begin
        lat4 = k; r4 = bus4.result_out;
      end
      if (lat1 >= 0 && lat4 >= 0 && k >= lat1 + 3) break;
    end
    stall = 1'b0;
  endtask

  task automatic test_reset();
    if ({bus1.busy, bus1.valid_out} !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl1: got busy/valid %b expected 00", {bus1.busy, bus1.valid_out});
    end
    checks++;
    if ({bus1.result_out, bus1.rd_address_out} !== 37'd0) begin
      errors++; $display("FAIL reset_data1: got %h expected 0", {bus1.result_out, bus1.rd_address_out});
    end
    checks++;
    if ({bus4.busy, bus4.valid_out, bus4.result_out, bus4.rd_address_out} !== 39'd0) begin
      errors++; $display("FAIL reset_all4: got %h expected 0",
                         {bus4.busy, bus4.valid_out, bus4.result_out, bus4.rd_address_out});
    end
    checks++;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[$];
    int lat1, lat4, busy1, pulse1, el1, el4;
    logic [31:0] r1, r4;
    logic [4:0] rd1, d;
    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'h7FFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{3'd5, 32'hFFFF_FFFF,  32'd3,         32'h5555_5555});
    vecs.push_back('{3'd7, 32'hFFFF_FFFF,  32'd7,         32'd3});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5});
    vecs.push_back('{3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    foreach (vecs[i]) begin
      d = 5'(i);
      el1 = is_special(vecs[i].f, vecs[i].a, vecs[i].b) ? 1 : 33;
      el4 = is_special(vecs[i].f, vecs[i].a, vecs[i].b) ? 1 : 9;
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, d, 0, -1, lat1, lat4, busy1, pulse1, r1, r4, rd1);
      if (r1 !== vecs[i].exp) begin
        errors++; $display("FAIL dir%0d_result1: got %h expected %h", i, r1, vecs[i].exp);
      end
      checks++;
      if (r4 !== vecs[i].exp) begin
        errors++; $display("FAIL dir%0d_result4: got %h expected %h", i, r4, vecs[i].exp);
      end
      checks++;
      if (lat1 !== el1 || lat4 !== el4) begin
        errors++; $display("FAIL dir%0d_latency: got %0d/%0d expected %0d/%0d", i, lat1, lat4, el1, el4);
      end
      checks++;
      if (busy1 !== el1 || pulse1 !== 1) begin
        errors++; $display("FAIL dir%0d_busy_pulse: got busy %0d pulse %0d expected %0d 1", i, busy1, pulse1, el1);
      end
      checks++;
      if (rd1 !== d) begin
        errors++; $display("FAIL dir%0d_rd: got %0d expected %0d", i, rd1, d);
      end
      checks++;
    end
  endtask

  task automatic test_stall();
    int lat1, lat4, busy1, pulse1, bad, lat;
    logic [31:0] r1, r4, prev;
    logic [4:0] rd1;
    run_op(3'd5, 32'd5, 32'd0, 5'd3, 0, -1, lat1, lat4, busy1, pulse1, r1, r4, rd1);
    prev = 32'hFFFF_FFFF;
    bad = 0; lat = -1;
    @(negedge clk);
    func = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; rd = 5'd9; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      stall = (k >= 30) && (k <= 35);
      @(posedge clk); #1;
      if (k >= 33 && k <= 35 &&
          (bus1.busy !== 1'b1 || bus1.valid_out !== 1'b0 || bus1.result_out !== prev)) bad++;
      if (bus1.valid_out && lat < 0) begin
        lat = k; r1 = bus1.result_out;
      end
    end
    stall = 1'b0;
    if (bad !== 0) begin
      errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (lat !== 36) begin
      errors++; $display("FAIL stall_latency: got %0d expected 36", lat);
    end
    checks++;
    if (r1 !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL stall_result: got %h expected fffffffd", r1);
    end
    checks++;
  endtask

  task automatic test_invalidate();
    int seen;
    @(negedge clk);
    func = 3'd0; rs1 = 32'd11; rs2 = 32'd13; rd = 5'd4; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    if (bus1.busy !== 1'b0 || bus1.valid_out !== 1'b0) begin
      errors++; $display("FAIL inval_flush: got busy %b valid %b expected 0 0", bus1.busy, bus1.valid_out);
    end
    checks++;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus1.valid_out) seen++;
    end
    if (seen !== 0) begin
      errors++; $display("FAIL inval_no_result: got %0d valid cycles expected 0", seen);
    end
    checks++;
    @(negedge clk);
    valid_in = 1'b1; invalidate = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; invalidate = 1'b0;
    if (bus1.busy !== 1'b0 || bus4.busy !== 1'b0) begin
      errors++; $display("FAIL inval_blocks_accept: got busy %b%b expected 00", bus1.busy, bus4.busy);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int lat1, lat4, busy1, pulse1;
    logic [31:0] r1, r4, e;
    logic [4:0] rd1;
    @(negedge clk);
    func = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; rd = 5'd2; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    if (bus1.busy !== 1'b0 || bus1.valid_out !== 1'b0 || bus1.result_out !== 32'd0) begin
      errors++; $display("FAIL reset_mid1: got busy %b valid %b result %h expected 0 0 0",
                         bus1.busy, bus1.valid_out, bus1.result_out);
    end
    checks++;
    if (bus4.result_out !== 32'd0) begin
      errors++; $display("FAIL reset_mid4: got result %h expected 0", bus4.result_out);
    end
    checks++;
    @(negedge clk);
    reset = 1'b0;
    e = ref_op(3'd6, 32'hFFFF_FC18, 32'd7);
    run_op(3'd6, 32'hFFFF_FC18, 32'd7, 5'd17, 0, -1, lat1, lat4, busy1, pulse1, r1, r4, rd1);
    if (r1 !== e || lat1 !== 33 || rd1 !== 5'd17) begin
      errors++; $display("FAIL reset_recover: got %h lat %0d rd %0d expected %h 33 17", r1, lat1, rd1, e);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int e1[$], e4[$];
    logic [31:0] bad_res;
    bad_res = '0;
    @(negedge clk);
    func = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd6; valid_in = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (bus1.valid_out) begin
        e1.push_back(k);
        if (bus1.result_out !== 32'd14) bad_res = bus1.result_out;
      end
      if (bus4.valid_out) begin
        e4.push_back(k);
        if (bus4.result_out !== 32'd14) bad_res = bus4.result_out;
      end
    end
    valid_in = 1'b0;
    invalidate = 1'b1;
    @(posedge clk); #1;
    invalidate = 1'b0;
    if (e1.size() !== 2 || e1[0] !== 33 || e1[1] !== 67) begin
      errors++; $display("FAIL b2b_step1: got %0d results first %0d expected 2 at 33 67",
                         e1.size(), (e1.size() > 0) ? e1[0] : -1);
    end
    checks++;
    if (e4.size() !== 7 || e4[0] !== 9 || e4[1] !== 19) begin
      errors++; $display("FAIL b2b_step4: got %0d results first %0d expected 7 at 9 19",
                         e4.size(), (e4.size() > 0) ? e4[0] : -1);
    end
    checks++;
    if (bad_res !== 32'd0) begin
      errors++; $display("FAIL b2b_result: got %h expected 0000000e", bad_res);
    end
    checks++;
  endtask

  task automatic test_random();
    int lat1, lat4, busy1, pulse1, el1, el4;
    logic [31:0] a, b, e, r1, r4;
    logic [2:0] f;
    logic [4:0] rd1;
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      e = ref_op(f, a, b);
      el1 = is_special(f, a, b) ? 1 : 33;
      el4 = is_special(f, a, b) ? 1 : 9;
      run_op(f, a, b, 5'($urandom_range(0, 31)), 0, -1, lat1, lat4, busy1, pulse1, r1, r4, rd1);
      if (r1 !== e || r4 !== e) begin
        errors++; $display("FAIL rnd%0d_f%0d a=%h b=%h: got %h/%h expected %h", i, f, a, b, r1, r4, e);
      end
      checks++;
      if (lat1 !== el1 || lat4 !== el4) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d/%0d expected %0d/%0d", i, lat1, lat4, el1, el4);
      end
      checks++;
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; stall = 1'b0; invalidate = 1'b0;
    func = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_directed();
    test_stall();
    test_invalidate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
